// File: rtl/router_reg.sv
// router_reg: router datapath register that captures the header, buffers a byte while the FIFO is full,
// and checks the packet's parity.
module router_reg (
  input  logic       clk,
  input  logic       resetn,
  input  logic       packet_valid,
  input  logic [7:0] data_in,
  input  logic       fifo_full,
  input  logic       detect_add,
  input  logic       lfd_state,
  input  logic       ld_state,
  input  logic       laf_state,
  input  logic       full_state,
  input  logic       rst_int_reg,
  output logic [7:0] dout,
  output logic       parity_done,
  output logic       low_packet_valid,
  output logic       err
);
  logic [7:0] r_dout, r_header_byte, r_full_byte, r_int_parity, r_pkt_parity;
  logic       r_parity_done, r_low_pv, r_err;
  logic       w_hdr_accept, w_unused;
  assign w_hdr_accept = detect_add && packet_valid && data_in[1:0] != 2'b11;
  assign w_unused     = full_state;
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_dout        <= 8'h00;
      r_header_byte <= 8'h00;
      r_full_byte   <= 8'h00;
      r_int_parity  <= 8'h00;
      r_pkt_parity  <= 8'h00;
      r_parity_done <= 1'b0;
      r_low_pv      <= 1'b0;
      r_err         <= 1'b0;
    end else begin
      if (w_hdr_accept) r_header_byte <= data_in;
      if (lfd_state) r_dout <= r_header_byte;
      else if (ld_state && !fifo_full) r_dout <= data_in;
      else if (laf_state) r_dout <= r_full_byte;
      if (ld_state && fifo_full) r_full_byte <= data_in;
      // Payload bytes enter the parity on their ld_state cycle, even when diverted to full_byte.
      if (w_hdr_accept) r_int_parity <= 8'h00;
      else if (lfd_state) r_int_parity <= r_int_parity ^ r_header_byte;
      else if (ld_state && packet_valid) r_int_parity <= r_int_parity ^ data_in;
      if (w_hdr_accept) r_pkt_parity <= 8'h00;
      else if (ld_state && !packet_valid) r_pkt_parity <= data_in;
      if (w_hdr_accept) r_parity_done <= 1'b0;
      else if ((ld_state && !fifo_full && !packet_valid) || (laf_state && r_low_pv && !r_parity_done))
        r_parity_done <= 1'b1;
      if (rst_int_reg) r_low_pv <= 1'b0;
      else if (ld_state && !packet_valid) r_low_pv <= 1'b1;
      if (w_hdr_accept) r_err <= 1'b0;
      else if (r_parity_done) r_err <= r_int_parity != r_pkt_parity;
    end
  end
  assign dout             = r_dout;
  assign parity_done      = r_parity_done;
  assign low_packet_valid = r_low_pv;
  assign err              = r_err;
endmodule

// File: tb/tb_router_reg.sv
// tb_router_reg: scenario tasks plus randomized packets checked against a byte-order/XOR packet model.
module tb_router_reg;
  logic clk = 0, resetn = 0, packet_valid = 0, fifo_full = 0, detect_add = 0;
  logic lfd_state = 0, ld_state = 0, laf_state = 0, full_state = 0, rst_int_reg = 0;
  logic [7:0] data_in = 0, dout;
  logic parity_done, low_packet_valid, err;
  int tests = 0, fails = 0;

  always #5 clk = ~clk;

  router_reg dut (
    .clk(clk), .resetn(resetn), .packet_valid(packet_valid), .data_in(data_in),
    .fifo_full(fifo_full), .detect_add(detect_add), .lfd_state(lfd_state),
    .ld_state(ld_state), .laf_state(laf_state), .full_state(full_state),
    .rst_int_reg(rst_int_reg), .dout(dout), .parity_done(parity_done),
    .low_packet_valid(low_packet_valid), .err(err)
  );

  task automatic drive(input logic da, lfd, ld, laf, pv, ff, rir, input logic [7:0] d);
    detect_add = da; lfd_state = lfd; ld_state = ld; laf_state = laf;
    packet_valid = pv; fifo_full = ff; rst_int_reg = rir; data_in = d;
    full_state = 1'($urandom);
    @(posedge clk); #1;
  endtask

  // One packet: header, payload (bit i of full_mask stalls byte i), parity byte.
  task automatic run_pkt(input logic [7:0] hdr, input logic [7:0] pay[$],
                         input logic [7:0] full_mask, input logic par_full, input logic [7:0] par);
    logic [7:0] calc, last;
    logic exp_err;
    calc = hdr;
    foreach (pay[i]) calc ^= pay[i];
    exp_err = calc != par;
    drive(1, 0, 0, 0, 1, 0, 0, hdr);
    tests++; if (parity_done !== 1'b0 || err !== 1'b0) begin fails++;
      $display("FAIL hdr_clear got pd=%b err=%b exp 0/0", parity_done, err); end
    drive(0, 1, 0, 0, 1, 0, 0, 8'($urandom));
    tests++; if (dout !== hdr) begin fails++; $display("FAIL lfd_dout got %h exp %h", dout, hdr); end
    last = hdr;
    foreach (pay[i]) begin
      if (full_mask[i]) begin
        drive(0, 0, 1, 0, 1, 1, 0, pay[i]);
        tests++; if (dout !== last) begin fails++; $display("FAIL full_hold got %h exp %h", dout, last); end
        drive(0, 0, 0, 1, 1, 0, 0, 8'($urandom));
        tests++; if (dout !== pay[i]) begin fails++; $display("FAIL laf_replay got %h exp %h", dout, pay[i]); end
      end else begin
        drive(0, 0, 1, 0, 1, 0, 0, pay[i]);
        tests++; if (dout !== pay[i]) begin fails++; $display("FAIL ld_dout got %h exp %h", dout, pay[i]); end
      end
      last = pay[i];
    end
    if (par_full) begin
      drive(0, 0, 1, 0, 0, 1, 0, par);
      tests++; if (dout !== last || parity_done !== 1'b0 || low_packet_valid !== 1'b1) begin fails++;
        $display("FAIL par_full got dout=%h pd=%b lpv=%b exp %h/0/1", dout, parity_done, low_packet_valid, last); end
      drive(0, 0, 0, 1, 0, 0, 0, 8'($urandom));
    end else drive(0, 0, 1, 0, 0, 0, 0, par);
    tests++; if (dout !== par || parity_done !== 1'b1) begin fails++;
      $display("FAIL par_dout got dout=%h pd=%b exp %h/1", dout, parity_done, par); end
    drive(0, 0, 0, 0, 0, 0, 0, 8'($urandom));
    tests++; if (err !== exp_err) begin fails++; $display("FAIL err got %b exp %b", err, exp_err); end
    drive(0, 0, 0, 0, 0, 0, 1, 8'h00);
    tests++; if (low_packet_valid !== 1'b0 || parity_done !== 1'b1 || err !== exp_err) begin fails++;
      $display("FAIL end_pkt got lpv=%b pd=%b err=%b exp 0/1/%b", low_packet_valid, parity_done, err, exp_err); end
  endtask

  task automatic test_reset();
    resetn = 0;
    drive(0, 0, 0, 0, 0, 0, 0, 8'h00);
    drive(0, 0, 0, 0, 0, 0, 0, 8'h00);
    tests++; if (dout !== 8'h00 || parity_done !== 1'b0 || low_packet_valid !== 1'b0 || err !== 1'b0) begin
      fails++; $display("FAIL reset got dout=%h pd=%b lpv=%b err=%b exp 0", dout, parity_done, low_packet_valid, err); end
    resetn = 1;
  endtask

  task automatic test_good();
    run_pkt(8'h05, '{8'hA3, 8'h3C}, 8'h00, 1'b0, 8'h9A);
  endtask

  task automatic test_bad_parity();
    run_pkt(8'h05, '{8'hA3, 8'h3C}, 8'h00, 1'b0, 8'h9B);
    repeat (3) drive(0, 0, 0, 0, 0, 0, 0, 8'($urandom));
    tests++; if (err !== 1'b1) begin fails++; $display("FAIL err_hold got %b exp 1", err); end
  endtask

  task automatic test_invalid_addr();
    drive(1, 0, 0, 0, 1, 0, 0, 8'h07);
    tests++; if (err !== 1'b1) begin fails++; $display("FAIL bad_addr_err got %b exp 1", err); end
    drive(0, 1, 0, 0, 1, 0, 0, 8'h00);
    tests++; if (dout !== 8'h05) begin fails++; $display("FAIL bad_addr_hdr got %h exp 05", dout); end
  endtask

  task automatic test_full_mid();
    run_pkt(8'h05, '{8'hA3, 8'h3C}, 8'h02, 1'b0, 8'h9A);
  endtask

  task automatic test_parity_full();
    run_pkt(8'h05, '{8'hA3, 8'h3C}, 8'h00, 1'b1, 8'h9A);
  endtask

  task automatic test_lpv_clear_wins();
    drive(0, 0, 1, 0, 0, 0, 0, 8'h11);
    tests++; if (low_packet_valid !== 1'b1) begin fails++; $display("FAIL lpv_set got %b exp 1", low_packet_valid); end
    drive(0, 0, 1, 0, 0, 0, 1, 8'h11);
    tests++; if (low_packet_valid !== 1'b0) begin fails++; $display("FAIL lpv_clear_wins got %b exp 0", low_packet_valid); end
  endtask

  task automatic test_mid_reset();
    run_pkt(8'h05, '{8'hA3}, 8'h00, 1'b0, 8'h00);
    drive(1, 0, 0, 0, 1, 0, 0, 8'h06);
    drive(0, 1, 0, 0, 1, 0, 0, 8'h00);
    drive(0, 0, 1, 0, 1, 0, 0, 8'h5A);
    resetn = 0;
    drive(0, 0, 1, 0, 1, 0, 0, 8'h77);
    resetn = 1;
    tests++; if (dout !== 8'h00 || parity_done !== 1'b0 || low_packet_valid !== 1'b0 || err !== 1'b0) begin
      fails++; $display("FAIL mid_reset got dout=%h pd=%b lpv=%b err=%b exp 0", dout, parity_done, low_packet_valid, err); end
    run_pkt(8'h05, '{8'hA3, 8'h3C}, 8'h00, 1'b0, 8'h9A);
  endtask

  task automatic test_random();
    for (int n = 0; n < 25; n++) begin
      logic [7:0] hdr, par, calc;
      logic [7:0] pay[$];
      int len;
      hdr = {6'($urandom), 2'($urandom_range(0, 2))};
      len = $urandom_range(1, 6);
      pay = {};
      calc = hdr;
      for (int i = 0; i < len; i++) begin
        pay.push_back(8'($urandom));
        calc ^= pay[i];
      end
      par = $urandom_range(0, 1) ? calc : calc ^ (8'h01 << $urandom_range(0, 7));
      run_pkt(hdr, pay, 8'($urandom), 1'($urandom), par);
    end
  endtask

  initial begin
    test_reset();
    test_good();
    test_bad_parity();
    test_invalid_addr();
    test_full_mid();
    test_parity_full();
    test_lpv_clear_wins();
    test_bad_parity();
    test_mid_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/router_reg.md
ROUTER_REG -- requirements
Module: router_reg

Interface
REQ-001 SHALL: clk  input  1  rising-edge clock for all state.
REQ-002 SHALL: resetn  input  1  reset, synchronous, active-low; clock clk.
REQ-003 SHALL: packet_valid  input  1  source packet framing; high for header and payload, low for the parity byte.
REQ-004 SHALL: data_in  input  8  source byte; header bits [1:0] carry the destination address.
REQ-005 SHALL: fifo_full  input  1  full flag of the currently selected output FIFO.
REQ-006 SHALL: detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg  input  1 each  state decodes from the router control FSM.
REQ-007 SHALL: dout  output  8  byte presented to the selected FIFO write port.
REQ-008 SHALL: parity_done  output  1  high once the packet parity byte has been captured.
REQ-009 SHALL: low_packet_valid  output  1  high once packet_valid has dropped inside the current packet.
REQ-010 SHALL: err  output  1  high when the received parity differs from the computed parity.

Function
REQ-011 SHALL: "header accept" = detect_add && packet_valid && data_in[1:0] != 2'b11; address 2'b11 accepts nothing and changes no register.
REQ-012 SHALL: on header accept: header_byte <= data_in; internal_parity, packet_parity, parity_done and err <= 0.
REQ-013 SHALL: dout update, in priority order: lfd_state -> header_byte; ld_state && !fifo_full -> data_in; laf_state -> full_byte; all other cases -> hold.
REQ-014 SHALL: ld_state && fifo_full -> full_byte <= data_in, dout holds; this byte is the one replayed in laf_state.
REQ-015 SHALL: internal_parity ^= header_byte in lfd_state.
REQ-016 SHALL: internal_parity ^= data_in in every ld_state && packet_valid cycle, whether fifo_full is high or low, so each payload byte is counted exactly once.
REQ-017 SHALL: packet_parity <= data_in in the ld_state && !packet_valid cycle, whether fifo_full is high or low.
REQ-018 SHALL: parity_done set (registered, visible next cycle) on ld_state && !fifo_full && !packet_valid, or on laf_state && low_packet_valid && !parity_done.
REQ-019 SHALL: parity_done cleared only by header accept or reset; otherwise holds.
REQ-020 SHALL: low_packet_valid set on ld_state && !packet_valid.
REQ-021 SHALL: low_packet_valid cleared on rst_int_reg; clear wins when set and clear coincide.
REQ-022 SHALL: err <= (internal_parity != packet_parity) on every cycle parity_done is high; err holds while parity_done is low; err is cleared only by header accept or reset.
REQ-023 SHALL: end-to-end latency: a byte on data_in appears on dout one clk after its ld_state cycle; the header appears one clk after lfd_state.
REQ-024 SHALL: full_state is ignored for data and parity (interface completeness only); the block contains no combinational path from any input to any output.

Reset
REQ-025 SHALL: resetn low at a clk edge -> dout, header_byte, full_byte, internal_parity and packet_parity = 8'h00; parity_done, low_packet_valid and err = 0.
REQ-026 SHALL: reset overrides every other condition, including mid-packet and during laf_state.

Verification
REQ-027 SHALL: Good packet: header 8'h05, payload A3/3C, parity 9A, no full -> dout sequence 05, A3, 3C, 9A; parity_done rises after the parity cycle; err stays 0.
REQ-028 SHALL: Bad parity: same stimulus with parity 9B -> err = 1 one cycle after parity_done rises; err holds through idle until the next header accept clears it.
REQ-029 SHALL: Full mid-payload: fifo_full=1 in the ld_state cycle with data_in=3C -> dout holds A3; full_byte=3C; after laf_state, dout=3C; final parity 9A gives err=0.
REQ-030 SHALL: Parity byte while full: fifo_full=1 in the ld_state && !packet_valid cycle with data_in=9A -> packet_parity=9A; parity_done=0 until laf_state with low_packet_valid=1, then parity_done=1; err=0.
REQ-031 SHALL: Invalid address: detect_add=1, packet_valid=1, data_in=8'h07 -> header_byte unchanged; a previous err=1 stays 1.
REQ-032 SHALL: Mid-packet reset: resetn=0 during ld_state with internal_parity nonzero -> all registers and outputs 0 on the next edge; the following good packet produces err=0.
